// File: rtl/c7bbiu_pkg.sv
// Shared constants and types for the BIU read scheduler.
package c7bbiu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CNT_W  = 3;

  localparam logic [7:0]      AXI_LEN_1BEAT  = 8'd0;
  localparam logic [2:0]      AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0]      AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]      AXI_RESP_OKAY  = 2'b00;

  localparam logic [ID_W-1:0] DEF_IFU_ID     = 4'h0;
  localparam logic [ID_W-1:0] DEF_LSU_ID     = 4'h1;

  // Pending AR transfer held until the slave accepts it
  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } ar_slot_t;

  // Which requester wins the next tie
  typedef enum logic {
    RR_PREFER_IFU = 1'b0,
    RR_PREFER_LSU = 1'b1
  } rr_pref_e;

endpackage

// File: rtl/c7bbiu_outst_ctr.sv
// Saturating up/down counter of in-flight reads for one requester.
module c7bbiu_outst_ctr
  import c7bbiu_pkg::*;
#(
  parameter int unsigned MAX = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt >= CNT_W'(MAX));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/c7bbiu_rd_sched.sv
// BIU read scheduler: round-robin AR sharing between IFU and LSU,
// per-requester in-flight tracking, R routing by ID and IFU cancel.
module c7bbiu_rd_sched
  import c7bbiu_pkg::*;
#(
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [ID_W-1:0] IFU_ID    = DEF_IFU_ID,
  parameter logic [ID_W-1:0] LSU_ID    = DEF_LSU_ID
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_rd_req,
  input  logic [ADDR_W-1:0] ifu_rd_addr,
  output logic              ifu_rd_ack,
  input  logic              ifu_cancel,
  input  logic              lsu_rd_req,
  input  logic [ADDR_W-1:0] lsu_rd_addr,
  output logic              lsu_rd_ack,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ID_W-1:0]   ar_id,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ID_W-1:0]   r_id,
  input  logic              r_last,
  input  logic [1:0]        r_resp,
  output logic              ifu_rdata_val,
  output logic              lsu_rdata_val,
  output logic              rd_err,
  output logic              unexp_rsp
);

  ar_slot_t         r_slot;
  ar_slot_t         w_slot_nxt;
  rr_pref_e         r_rr;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_ifu_cnt;
  logic [CNT_W-1:0] w_lsu_cnt;
  logic             w_ifu_full, w_ifu_empty;
  logic             w_lsu_full, w_lsu_empty;
  logic             w_slot_free;
  logic             w_ifu_elig, w_lsu_elig;
  logic             w_grant_ifu, w_grant_lsu;
  logic             w_ifu_hit, w_lsu_hit;
  logic             w_ifu_dec, w_lsu_dec;

  // Arbitration; reset suppresses grants so nothing is counted while clearing
  assign w_slot_free = !r_slot.valid || ar_ready;
  assign w_ifu_elig  = ifu_rd_req && !w_ifu_full && !reset;
  assign w_lsu_elig  = lsu_rd_req && !w_lsu_full && !reset;
  assign w_grant_ifu = w_slot_free && w_ifu_elig && (!w_lsu_elig || (r_rr == RR_PREFER_IFU));
  assign w_grant_lsu = w_slot_free && w_lsu_elig && (!w_ifu_elig || (r_rr == RR_PREFER_LSU));

  assign ifu_rd_ack  = w_grant_ifu;
  assign lsu_rd_ack  = w_grant_lsu;

  // A beat is only "ours" when its ID matches and that requester has reads in flight
  assign w_ifu_hit   = r_valid && (r_id == IFU_ID) && !w_ifu_empty && !reset;
  assign w_lsu_hit   = r_valid && (r_id == LSU_ID) && !w_lsu_empty && !reset;
  assign w_ifu_dec   = w_ifu_hit && r_last;
  assign w_lsu_dec   = w_lsu_hit && r_last;

  assign ifu_rdata_val = w_ifu_hit && (r_drop == '0);
  assign lsu_rdata_val = w_lsu_hit;
  assign rd_err        = (ifu_rdata_val || lsu_rdata_val) && (r_resp != AXI_RESP_OKAY);
  assign unexp_rsp     = r_valid && !reset && !w_ifu_hit && !w_lsu_hit;

  c7bbiu_outst_ctr #(.MAX(MAX_OUTST)) u_ifu_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_grant_ifu),
    .i_dec   (w_ifu_dec),
    .o_cnt   (w_ifu_cnt),
    .o_full  (w_ifu_full),
    .o_empty (w_ifu_empty)
  );

  c7bbiu_outst_ctr #(.MAX(MAX_OUTST)) u_lsu_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_grant_lsu),
    .i_dec   (w_lsu_dec),
    .o_cnt   (w_lsu_cnt),
    .o_full  (w_lsu_full),
    .o_empty (w_lsu_empty)
  );

  // AR slot next value: load on grant, retire on accept
  always_comb begin
    w_slot_nxt = r_slot;
    if (w_grant_ifu) begin
      w_slot_nxt = '{valid: 1'b1, id: IFU_ID, addr: ifu_rd_addr};
    end else if (w_grant_lsu) begin
      w_slot_nxt = '{valid: 1'b1, id: LSU_ID, addr: lsu_rd_addr};
    end else if (ar_ready) begin
      w_slot_nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
    end else begin
      r_slot <= w_slot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= RR_PREFER_LSU;
    end else if (w_grant_ifu) begin
      r_rr <= RR_PREFER_LSU;
    end else if (w_grant_lsu) begin
      r_rr <= RR_PREFER_IFU;
    end
  end

  // Cancel snapshots the post-edge IFU count; those many IFU reads are then dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= '0;
    end else if (ifu_cancel) begin
      r_drop <= w_ifu_cnt + CNT_W'(w_grant_ifu) - CNT_W'(w_ifu_dec);
    end else if (w_ifu_dec && (r_drop != '0)) begin
      r_drop <= r_drop - CNT_W'(1);
    end
  end

  assign ar_valid = r_slot.valid;
  assign ar_id    = r_slot.id;
  assign ar_addr  = r_slot.addr;
  assign ar_len   = AXI_LEN_1BEAT;
  assign ar_size  = AXI_SIZE_4B;
  assign ar_burst = AXI_BURST_INCR;
  assign r_ready  = 1'b1;

endmodule

// File: tb/tb_c7bbiu_rd_sched.sv
// Bench for c7bbiu_rd_sched: directed scenarios with literal expectations,
// then randomized traffic against a queue/count based reference model.
module tb_c7bbiu_rd_sched;

  localparam int         MAXO  = 2;
  localparam logic [3:0] T_IFU = 4'h0;
  localparam logic [3:0] T_LSU = 4'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_rd_req, ifu_rd_ack, ifu_cancel;
  logic [31:0] ifu_rd_addr;
  logic        lsu_rd_req, lsu_rd_ack;
  logic [31:0] lsu_rd_addr;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        ifu_rdata_val, lsu_rdata_val, rd_err, unexp_rsp;

  always #5 clk = ~clk;

  c7bbiu_rd_sched dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_ack(ifu_rd_ack),
    .ifu_cancel(ifu_cancel),
    .lsu_rd_req(lsu_rd_req), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_ack(lsu_rd_ack),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_last(r_last), .r_resp(r_resp),
    .ifu_rdata_val(ifu_rdata_val), .lsu_rdata_val(lsu_rdata_val),
    .rd_err(rd_err), .unexp_rsp(unexp_rsp)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: in-flight counts, reads to drop, tie preference, AR slot
  int          m_ci, m_cl, m_drop;
  bit          m_pref_lsu;
  bit          m_sv;
  logic [3:0]  m_sid;
  logic [31:0] m_saddr;
  bit          e_gi, e_gl, e_hi, e_hl, e_iv, e_lv, e_err, e_unx;
  bit          auto_slave = 1'b0;
  int          sq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Expected same-cycle outputs from the current model state and inputs
  task automatic model_eval();
    bit ei, el, free;
    ei   = ifu_rd_req && (m_ci < MAXO) && !reset;
    el   = lsu_rd_req && (m_cl < MAXO) && !reset;
    free = !m_sv || ar_ready;
    e_gi = 1'b0;
    e_gl = 1'b0;
    if (free) begin
      if (ei && el) begin
        if (m_pref_lsu) e_gl = 1'b1; else e_gi = 1'b1;
      end else begin
        e_gi = ei;
        e_gl = el;
      end
    end
    e_hi  = !reset && r_valid && (r_id == T_IFU) && (m_ci > 0);
    e_hl  = !reset && r_valid && (r_id == T_LSU) && (m_cl > 0);
    e_iv  = e_hi && (m_drop == 0);
    e_lv  = e_hl;
    e_err = (e_iv || e_lv) && (r_resp != 2'b00);
    e_unx = !reset && r_valid && !e_hi && !e_hl;
  endtask

  // Model state advance at a clock edge
  task automatic model_edge();
    int di, dl;
    if (auto_slave && m_sv && ar_ready) sq.push_back(int'(m_sid));
    if (reset) begin
      m_ci = 0; m_cl = 0; m_drop = 0; m_pref_lsu = 1'b1;
      m_sv = 1'b0; m_sid = 4'h0; m_saddr = 32'h0;
    end else begin
      di = (e_hi && r_last) ? 1 : 0;
      dl = (e_hl && r_last) ? 1 : 0;
      if (ifu_cancel) m_drop = m_ci + int'(e_gi) - di;
      else if (di == 1 && m_drop > 0) m_drop = m_drop - 1;
      m_ci = m_ci + int'(e_gi) - di;
      m_cl = m_cl + int'(e_gl) - dl;
      if (e_gi) begin
        m_sv = 1'b1; m_sid = T_IFU; m_saddr = ifu_rd_addr;
      end else if (e_gl) begin
        m_sv = 1'b1; m_sid = T_LSU; m_saddr = lsu_rd_addr;
      end else if (ar_ready) begin
        m_sv = 1'b0;
      end
      if (e_gi) m_pref_lsu = 1'b1;
      else if (e_gl) m_pref_lsu = 1'b0;
    end
  endtask

  // One cycle: edge, drive inputs, settle, compare every output against the model
  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit lr, input logic [31:0] la, input bit ard,
                      input bit rv, input logic [3:0] rid, input bit rl,
                      input logic [1:0] rsp, input bit can);
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; ifu_rd_req = ir; ifu_rd_addr = ia; lsu_rd_req = lr; lsu_rd_addr = la;
    ar_ready = ard; r_valid = rv; r_id = rid; r_last = rl; r_resp = rsp; ifu_cancel = can;
    #2;
    model_eval();
    chk("ifu_rd_ack",    32'(ifu_rd_ack),    32'(e_gi));
    chk("lsu_rd_ack",    32'(lsu_rd_ack),    32'(e_gl));
    chk("ar_valid",      32'(ar_valid),      32'(m_sv));
    chk("ar_id",         32'(ar_id),         32'(m_sid));
    chk("ar_addr",       ar_addr,            m_saddr);
    chk("ifu_rdata_val", 32'(ifu_rdata_val), 32'(e_iv));
    chk("lsu_rdata_val", 32'(lsu_rdata_val), 32'(e_lv));
    chk("rd_err",        32'(rd_err),        32'(e_err));
    chk("unexp_rsp",     32'(unexp_rsp),     32'(e_unx));
  endtask

  task automatic idle(input bit ard);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ard, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic beat(input logic [3:0] rid, input logic [1:0] rsp);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, rid, 1'b1, rsp, 1'b0);
  endtask

  bit          exp_l[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit          exp_i[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  bit          g_ard, g_rv, g_rl, g_can, g_rst, g_ir, g_lr;
  logic [3:0]  g_rid;
  logic [1:0]  g_rsp;
  logic [31:0] g_ia, g_la;
  int          g_k, g_j;

  initial begin
    reset = 1'b1; ifu_rd_req = 1'b0; ifu_rd_addr = 32'h0; ifu_cancel = 1'b0;
    lsu_rd_req = 1'b0; lsu_rd_addr = 32'h0; ar_ready = 1'b0;
    r_valid = 1'b0; r_id = 4'h0; r_last = 1'b0; r_resp = 2'b00;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("rst_ar_valid", 32'(ar_valid), 32'h0);
    chk("rst_ar_addr",  ar_addr,       32'h0);

    // Single IFU read end to end
    step(1'b0, 1'b1, 32'h1c000000, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("A_ifu_ack", 32'(ifu_rd_ack), 32'h1);
    idle(1'b1);
    chk("A_ar_valid", 32'(ar_valid), 32'h1);
    chk("A_ar_id",    32'(ar_id),    32'h0);
    chk("A_ar_addr",  ar_addr,       32'h1c000000);
    chk("A_ar_len",   32'(ar_len),   32'h0);
    chk("A_ar_size",  32'(ar_size),  32'h2);
    chk("A_ar_burst", 32'(ar_burst), 32'h1);
    chk("A_r_ready",  32'(r_ready),  32'h1);
    idle(1'b1);
    chk("A_ar_retired", 32'(ar_valid), 32'h0);
    beat(T_IFU, 2'b00);
    chk("A_ifu_rdata", 32'(ifu_rdata_val), 32'h1);
    chk("A_unexp",     32'(unexp_rsp),     32'h0);

    // Round robin with both requesting continuously; each stalls at two in flight
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, 32'h10000000, 1'b1, 32'h20000000, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
      chk("B_lsu_ack", 32'(lsu_rd_ack), 32'(exp_l[c]));
      chk("B_ifu_ack", 32'(ifu_rd_ack), 32'(exp_i[c]));
    end
    step(1'b0, 1'b1, 32'h10000000, 1'b1, 32'h20000000, 1'b1, 1'b1, T_LSU, 1'b1, 2'b10, 1'b0);
    chk("B_lsu_rdata", 32'(lsu_rdata_val), 32'h1);
    chk("B_rd_err",    32'(rd_err),        32'h1);
    chk("B_lsu_full",  32'(lsu_rd_ack),    32'h0);
    step(1'b0, 1'b1, 32'h10000000, 1'b1, 32'h20000000, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("B_lsu_reack", 32'(lsu_rd_ack), 32'h1);
    chk("B_ifu_full",  32'(ifu_rd_ack), 32'h0);

    // Unknown ID
    beat(4'h7, 2'b00);
    chk("C_unexp",     32'(unexp_rsp),     32'h1);
    chk("C_ifu_rdata", 32'(ifu_rdata_val), 32'h0);

    // Cancel with two IFU reads in flight
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b1);
    beat(T_IFU, 2'b00);
    chk("D_drop1", 32'(ifu_rdata_val), 32'h0);
    chk("D_drop1_unexp", 32'(unexp_rsp), 32'h0);
    beat(T_IFU, 2'b00);
    chk("D_drop2", 32'(ifu_rdata_val), 32'h0);
    step(1'b0, 1'b1, 32'h1c000040, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("D_ifu_ack", 32'(ifu_rd_ack), 32'h1);
    idle(1'b1);
    idle(1'b1);
    beat(T_IFU, 2'b00);
    chk("D_third_delivered", 32'(ifu_rdata_val), 32'h1);

    // AR backpressure with an LSU request waiting behind the slot
    beat(T_LSU, 2'b00);
    beat(T_LSU, 2'b00);
    chk("E_lsu_rdata", 32'(lsu_rdata_val), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h30000000, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("E_first_ack", 32'(lsu_rd_ack), 32'h1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h30000004, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
      chk("E_no_ack",   32'(lsu_rd_ack), 32'h0);
      chk("E_held_val", 32'(ar_valid),   32'h1);
      chk("E_held_adr", ar_addr,         32'h30000000);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h30000004, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("E_ack_on_accept", 32'(lsu_rd_ack), 32'h1);
    idle(1'b1);
    chk("E_second_addr", ar_addr, 32'h30000004);

    // Reset with one IFU and one LSU read in flight
    beat(T_LSU, 2'b00);
    step(1'b0, 1'b1, 32'h1c000080, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    chk("F_ifu_ack", 32'(ifu_rd_ack), 32'h1);
    idle(1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    idle(1'b1);
    chk("F_ar_valid", 32'(ar_valid), 32'h0);
    chk("F_ar_id",    32'(ar_id),    32'h0);
    chk("F_ar_addr",  ar_addr,       32'h0);
    beat(T_IFU, 2'b00);
    chk("F_late_ifu_unexp", 32'(unexp_rsp),     32'h1);
    chk("F_late_ifu_val",   32'(ifu_rdata_val), 32'h0);
    beat(T_LSU, 2'b00);
    chk("F_late_lsu_unexp", 32'(unexp_rsp), 32'h1);

    // Randomized traffic with an auto-responding slave
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
    sq.delete();
    auto_slave = 1'b1;
    g_ir = 1'b0; g_lr = 1'b0; g_ia = 32'h0; g_la = 32'h0;
    for (int n = 0; n < 4000; n++) begin
      if (g_ir && e_gi) g_ir = 1'b0;
      if (g_lr && e_gl) g_lr = 1'b0;
      if (!g_ir && ($urandom % 3) == 0) begin g_ir = 1'b1; g_ia = $urandom & 32'hffff_fffc; end
      if (!g_lr && ($urandom % 3) == 0) begin g_lr = 1'b1; g_la = $urandom & 32'hffff_fffc; end
      g_rv = 1'b0; g_rid = 4'h0; g_rl = 1'b0; g_rsp = 2'b00;
      g_k = int'($urandom % 100);
      if (sq.size() > 0 && g_k < 45) begin
        g_j   = int'($urandom_range(sq.size() - 1));
        g_rv  = 1'b1;
        g_rid = 4'(sq[g_j]);
        g_rl  = ($urandom % 6) != 0;
        if (g_rl) sq.delete(g_j);
      end else if (g_k >= 97) begin
        g_rv  = 1'b1;
        g_rid = 4'($urandom % 16);
        g_rl  = ($urandom % 2) == 1;
      end
      if (($urandom % 5) == 0) g_rsp = 2'($urandom % 4);
      g_ard = ($urandom % 10) < 7;
      g_can = ($urandom % 40) == 0;
      g_rst = ($urandom % 600) == 0;
      step(g_rst, g_ir, g_ia, g_lr, g_la, g_ard, g_rv, g_rid, g_rl, g_rsp, g_can);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
